// File: rtl/hack_debug_ctrl.sv
// Run-control and trace unit for the Hack CPU: run/halt/step, PC breakpoints, {pc,instr} trace ring.
// Optional instruction counter output enabled by defining HACK_DBG_INSTR_CNT_EN.
module hack_debug_ctrl #(
    parameter int unsigned NUM_BP      = 4,
    parameter int unsigned PC_W        = 15,
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned START_RUN   = 1,
    localparam int unsigned TRACE_AW   = $clog2(TRACE_DEPTH),
    localparam int unsigned BP_SW      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [PC_W-1:0]            pc,
    input  logic [INSTR_W-1:0]         instruction,
    input  logic                       cmd_run,
    input  logic                       cmd_halt,
    input  logic                       cmd_step,
    input  logic                       bp_wr,
    input  logic [BP_SW-1:0]           bp_sel,
    input  logic [PC_W-1:0]            bp_addr,
    input  logic                       bp_en,
    output logic                       cpu_ce,
    output logic                       halted,
    output logic [NUM_BP-1:0]          bp_hit,
    input  logic                       trace_rd,
    input  logic                       trace_clr,
    output logic [PC_W+INSTR_W-1:0]    trace_data,
    output logic                       trace_valid,
    output logic [TRACE_AW:0]          trace_count,
`ifdef HACK_DBG_INSTR_CNT_EN
    output logic [31:0]                instr_count,
`endif
    output logic                       trace_ovf
);

    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP} state_t;

    state_t                    r_state;
    logic                      r_skip_bp;
    logic [NUM_BP-1:0]         r_bp_en;
    logic [PC_W-1:0]           r_bp_addr [NUM_BP];
    logic [NUM_BP-1:0]         r_bp_hit;
    logic [NUM_BP-1:0]         w_match;
    logic                      w_ce;

    logic [PC_W+INSTR_W-1:0]   r_mem [TRACE_DEPTH];
    logic [TRACE_AW-1:0]       r_wr_ptr;
    logic [TRACE_AW-1:0]       r_rd_ptr;
    logic [TRACE_AW:0]         r_count;
    logic                      r_ovf;
    logic                      w_pop;
    logic                      w_full;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            w_match[i] = r_bp_en[i] && (r_bp_addr[i] == pc);
        end
    end

    // Breakpoints stop the CPU before the matching instruction; skip_bp lets a resume pass it once.
    always_comb begin
        w_ce = 1'b0;
        case (r_state)
            ST_RUN:  w_ce = !cmd_halt && (r_skip_bp || !(|w_match));
            ST_STEP: w_ce = 1'b1;
            default: w_ce = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bp_en <= '0;
            for (int i = 0; i < int'(NUM_BP); i++) r_bp_addr[i] <= '0;
        end else if (bp_wr) begin
            for (int i = 0; i < int'(NUM_BP); i++) begin
                if (bp_sel == BP_SW'(i)) begin
                    r_bp_en[i]   <= bp_en;
                    r_bp_addr[i] <= bp_addr;
                end
            end
        end
    end

    // Run-control state machine; command priority halt > step > run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= (START_RUN != 0) ? ST_RUN : ST_HALT;
            r_skip_bp <= 1'b1;
            r_bp_hit  <= '0;
        end else begin
            if (w_ce) r_skip_bp <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (cmd_halt) begin
                        r_state  <= ST_HALT;
                        r_bp_hit <= '0;
                    end else if (!r_skip_bp && (|w_match)) begin
                        r_state  <= ST_HALT;
                        r_bp_hit <= w_match;
                    end
                end
                ST_HALT: begin
                    if (!cmd_halt) begin
                        if (cmd_step) begin
                            r_state  <= ST_STEP;
                            r_bp_hit <= '0;
                        end else if (cmd_run) begin
                            r_state   <= ST_RUN;
                            r_skip_bp <= 1'b1;
                            r_bp_hit  <= '0;
                        end
                    end
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign w_full = (r_count == (TRACE_AW+1)'(TRACE_DEPTH));
    assign w_pop  = trace_rd && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_ce && !trace_clr) r_mem[r_wr_ptr] <= {pc, instruction};
    end

    // Ring pointers; a push into a full ring drops the oldest entry and flags overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (trace_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case ({w_ce, w_pop})
                2'b11: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                2'b10: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_full) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_ovf    <= 1'b1;
                    end else begin
                        r_count  <= r_count + 1'b1;
                    end
                end
                2'b01: begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_count  <= r_count - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HACK_DBG_INSTR_CNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        r_instr_count <= '0;
        else if (w_ce && (r_instr_count != '1)) r_instr_count <= r_instr_count + 1'b1;
    end

    assign instr_count = r_instr_count;
`endif

    assign cpu_ce      = w_ce;
    assign halted      = (r_state == ST_HALT);
    assign bp_hit      = r_bp_hit;
    assign trace_data  = r_mem[r_rd_ptr];
    assign trace_valid = (r_count != '0);
    assign trace_count = r_count;
    assign trace_ovf   = r_ovf;

endmodule

// File: tb/tb_hack_debug_ctrl.sv
// Bench for hack_debug_ctrl: CPU model advances pc on cpu_ce, trace scoreboard queue checked on pops.
module tb_hack_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] pc;
    logic [15:0] instruction;
    logic        cmd_run, cmd_halt, cmd_step;
    logic        bp_wr, bp_en;
    logic [1:0]  bp_sel;
    logic [14:0] bp_addr;
    logic        cpu_ce, halted;
    logic [3:0]  bp_hit;
    logic        trace_rd, trace_clr;
    logic [30:0] trace_data;
    logic        trace_valid;
    logic [4:0]  trace_count;
    logic        trace_ovf;
`ifdef HACK_DBG_INSTR_CNT_EN
    logic [31:0] instr_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [30:0] m_q[$];
    logic        m_ovf;

    always #5 clk = ~clk;

    function automatic logic [15:0] instr_of(input logic [14:0] p);
        return {1'b1, p} ^ 16'h5A3C;
    endfunction

    assign instruction = instr_of(pc);

    hack_debug_ctrl dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .instruction(instruction),
        .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
        .bp_wr(bp_wr), .bp_sel(bp_sel), .bp_addr(bp_addr), .bp_en(bp_en),
        .cpu_ce(cpu_ce), .halted(halted), .bp_hit(bp_hit),
        .trace_rd(trace_rd), .trace_clr(trace_clr), .trace_data(trace_data),
        .trace_valid(trace_valid), .trace_count(trace_count),
`ifdef HACK_DBG_INSTR_CNT_EN
        .instr_count(instr_count),
`endif
        .trace_ovf(trace_ovf)
    );

    // CPU model plus expected trace contents (depth 16, oldest dropped on overflow).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (cpu_ce) pc <= pc + 1'b1;
            if (trace_clr) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (trace_rd && m_q.size() > 0) void'(m_q.pop_front());
                if (cpu_ce) begin
                    if (m_q.size() == 16) begin
                        void'(m_q.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_q.push_back({pc, instr_of(pc)});
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        if (m_q.size() > 0) chk("trace_data", 64'(trace_data), 64'(m_q[0]));
        trace_rd = 1'b1;
        tick();
        trace_rd = 1'b0;
    endtask

    task automatic do_step();
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        tick();
    endtask

    task automatic write_bp(input logic [1:0] sel, input logic [14:0] addr, input logic en);
        bp_wr = 1'b1; bp_sel = sel; bp_addr = addr; bp_en = en;
        tick();
        bp_wr = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int i;
        for (i = 0; i < 60 && !halted; i++) tick();
        chk(tag, 64'(halted), 64'd1);
    endtask

    int          ce_cnt;
    logic [14:0] p0;

    initial begin
        reset_n = 1'b0;
        {cmd_run, cmd_halt, cmd_step, bp_wr, bp_en, trace_rd, trace_clr} = '0;
        bp_sel = '0; bp_addr = '0;
        tick(); tick();
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(trace_count), 64'd0);
        chk("rst_ovf", 64'(trace_ovf), 64'd0);
        chk("rst_bp_hit", 64'(bp_hit), 64'd0);

        // 1: free run after reset
        reset_n = 1'b1;
        #1;
        chk("run_ce0", 64'(cpu_ce), 64'd1);
        ce_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            ce_cnt += int'(cpu_ce);
            tick();
        end
        chk("run_ce_cycles", 64'(ce_cnt), 64'd10);
        chk("run_count", 64'(trace_count), 64'd10);
        chk("run_halted", 64'(halted), 64'd0);
        chk("run_pc", 64'(pc), 64'd10);
        for (int i = 0; i < 3; i++) pop_one();
        chk("run_count_model", 64'(trace_count), 64'(m_q.size()));

        // 2: breakpoint at 5 from pc 0
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        cmd_halt = 1'b1;
        #1;
        chk("halt_ce_low", 64'(cpu_ce), 64'd0);
        tick();
        cmd_halt = 1'b0;
        chk("halt_state", 64'(halted), 64'd1);
        chk("halt_pc", 64'(pc), 64'd0);
        write_bp(2'd1, 15'd5, 1'b1);
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        wait_halt("bp5_halted");
        chk("bp5_pc", 64'(pc), 64'd5);
        chk("bp5_hit", 64'(bp_hit), 64'b0010);
        chk("bp5_ce", 64'(cpu_ce), 64'd0);
        tick(); tick();
        chk("bp5_pc_hold", 64'(pc), 64'd5);
        write_bp(2'd2, 15'd8, 1'b1);
        write_bp(2'd3, 15'd8, 1'b1);
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk("resume_ce", 64'(cpu_ce), 64'd1);
        chk("resume_hit_clr", 64'(bp_hit), 64'd0);
        tick();
        chk("resume_pc", 64'(pc), 64'd6);
        wait_halt("bp8_halted");
        chk("bp8_pc", 64'(pc), 64'd8);
        chk("bp8_hit", 64'(bp_hit), 64'b1100);

        // 3: single-step over a breakpoint; commands during STEP ignored
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        chk("step_ce", 64'(cpu_ce), 64'd1);
        chk("step_halted", 64'(halted), 64'd0);
        chk("step_hit_clr", 64'(bp_hit), 64'd0);
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk("step_back_halt", 64'(halted), 64'd1);
        chk("step_pc", 64'(pc), 64'd9);
        tick(); tick();
        chk("step_pc_hold", 64'(pc), 64'd9);

        // 4: overflow and push+pop at full
        trace_clr = 1'b1;
        tick();
        trace_clr = 1'b0;
        chk("clr_count", 64'(trace_count), 64'd0);
        chk("clr_valid", 64'(trace_valid), 64'd0);
        p0 = pc;
        for (int i = 0; i < 20; i++) do_step();
        chk("ovf_count", 64'(trace_count), 64'd16);
        chk("ovf_flag", 64'(trace_ovf), 64'd1);
        chk("ovf_oldest", 64'(trace_data), 64'({p0 + 15'd4, instr_of(p0 + 15'd4)}));
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        pop_one();
        chk("full_pushpop_count", 64'(trace_count), 64'd16);
        chk("full_pushpop_ovf", 64'(trace_ovf), 64'(m_ovf));
        for (int i = 0; i < 20 && trace_count != 0; i++) pop_one();
        chk("drain_count", 64'(trace_count), 64'd0);
        chk("drain_valid", 64'(trace_valid), 64'd0);
        trace_rd = 1'b1;
        tick();
        trace_rd = 1'b0;
        chk("pop_empty", 64'(trace_count), 64'd0);
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        trace_rd = 1'b1;
        tick();
        trace_rd = 1'b0;
        chk("pushpop_empty", 64'(trace_count), 64'd1);
        chk("ovf_sticky", 64'(trace_ovf), 64'd1);
        trace_clr = 1'b1;
        tick();
        trace_clr = 1'b0;
        chk("clr_ovf", 64'(trace_ovf), 64'd0);

        // 5: halt+run together in RUN; async reset mid-run
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        tick(); tick();
        cmd_halt = 1'b1; cmd_run = 1'b1;
        #1;
        chk("halt_run_ce", 64'(cpu_ce), 64'd0);
        tick();
        cmd_halt = 1'b0; cmd_run = 1'b0;
        chk("halt_run_halted", 64'(halted), 64'd1);
        chk("halt_run_hit", 64'(bp_hit), 64'd0);
        chk("halt_run_model", 64'(trace_count), 64'(m_q.size()));
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(trace_count), 64'd0);
        chk("mid_rst_halted", 64'(halted), 64'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("bp_cleared_run", 64'(halted), 64'd0);
        chk("bp_cleared_pc", 64'(pc), 64'd12);

`ifdef HACK_DBG_INSTR_CNT_EN
        // 6: instruction counter over 7 steps
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        cmd_halt = 1'b1;
        tick();
        cmd_halt = 1'b0;
        chk("icnt_start", 64'(instr_count), 64'd0);
        for (int i = 0; i < 7; i++) do_step();
        chk("icnt_7", 64'(instr_count), 64'd7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
